// File: rtl/mux_n_stream.sv
`default_nettype none
// ============================================================================
// Module   : mux_n_stream
// Purpose  : N-to-1 registered stream mux with valid/ready on every port;
//            channel chosen by external select (MODE 0) or round-robin (MODE 1).
// Revision : 1.0  initial release
// ============================================================================
module mux_n_stream #(
  parameter int N    = 4,
  parameter int W    = 1,
  parameter int MODE = 1,
  localparam int SW  = (N < 3) ? 1 : $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [SW-1:0]  out_ch
);

  localparam logic [SW-1:0] c_last = SW'(N - 1);

  logic          w_load_en;
  logic          w_grant;
  logic [SW-1:0] w_g;
  logic [W-1:0]  w_data;
  logic [SW-1:0] r_ptr;

  // The output register can take a new word whenever it is empty or draining.
  assign w_load_en = !out_valid || out_ready;

  generate
    if (MODE == 0) begin : g_ext
      logic w_unused_ptr;
      assign w_unused_ptr = ^r_ptr;

      // Comparing against every legal index means an out-of-range sel never grants.
      always_comb begin
        w_grant = 1'b0;
        w_g     = '0;
        for (int k = 0; k < N; k++) begin
          if (sel == SW'(k) && in_valid[k]) begin
            w_grant = 1'b1;
            w_g     = SW'(k);
          end
        end
      end
    end else begin : g_rr
      logic           w_unused_sel;
      logic [2*N-1:0] w_dbl;
      logic [N-1:0]   w_rot;
      logic [SW-1:0]  w_off;
      logic [SW:0]    w_sum;

      assign w_unused_sel = ^sel;
      // Doubling the valid vector turns the modulo-N search into a plain window.
      assign w_dbl = {in_valid, in_valid};
      assign w_rot = w_dbl[r_ptr +: N];

      always_comb begin
        w_grant = 1'b0;
        w_off   = '0;
        for (int k = N - 1; k >= 0; k--) begin
          if (w_rot[k]) begin
            w_grant = 1'b1;
            w_off   = SW'(k);
          end
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum > {1'b0, c_last}) begin
          w_sum = w_sum - (SW+1)'(N);
        end
        w_g = w_sum[SW-1:0];
      end
    end
  endgenerate

  always_comb begin
    w_data   = '0;
    in_ready = '0;
    for (int k = 0; k < N; k++) begin
      if (w_g == SW'(k)) begin
        w_data      = in_data[k*W +: W];
        in_ready[k] = w_grant && w_load_en && rst_n;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      r_ptr     <= '0;
    end else if (w_load_en) begin
      if (w_grant) begin
        out_valid <= 1'b1;
        out_data  <= w_data;
        out_ch    <= w_g;
        if (MODE != 0) begin
          r_ptr <= (w_g == c_last) ? '0 : w_g + 1'b1;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_n_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_n_stream
// Purpose  : Self-checking bench: directed scenarios plus randomized traffic
//            against a queue-free behavioural model of three DUT configurations.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mux_n_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // u0: external select, N=4, W=8
  logic [31:0] m0_in_data;
  logic [3:0]  m0_in_valid, m0_in_ready;
  logic [1:0]  m0_sel, m0_out_ch;
  logic [7:0]  m0_out_data;
  logic        m0_out_valid, m0_out_ready;
  // u1: round-robin, N=4, W=8
  logic [31:0] m1_in_data;
  logic [3:0]  m1_in_valid, m1_in_ready;
  logic [1:0]  m1_sel, m1_out_ch;
  logic [7:0]  m1_out_data;
  logic        m1_out_valid, m1_out_ready;
  // u3: external select, N=3 (sel=3 is out of range), W=4
  logic [11:0] m3_in_data;
  logic [2:0]  m3_in_valid, m3_in_ready;
  logic [1:0]  m3_sel, m3_out_ch;
  logic [3:0]  m3_out_data;
  logic        m3_out_valid, m3_out_ready;

  mux_n_stream #(.N(4), .W(8), .MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_data(m0_in_data), .in_valid(m0_in_valid),
    .in_ready(m0_in_ready), .sel(m0_sel), .out_data(m0_out_data),
    .out_valid(m0_out_valid), .out_ready(m0_out_ready), .out_ch(m0_out_ch));

  mux_n_stream #(.N(4), .W(8), .MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_data(m1_in_data), .in_valid(m1_in_valid),
    .in_ready(m1_in_ready), .sel(m1_sel), .out_data(m1_out_data),
    .out_valid(m1_out_valid), .out_ready(m1_out_ready), .out_ch(m1_out_ch));

  mux_n_stream #(.N(3), .W(4), .MODE(0)) u3 (
    .clk(clk), .rst_n(rst_n), .in_data(m3_in_data), .in_valid(m3_in_valid),
    .in_ready(m3_in_ready), .sel(m3_sel), .out_data(m3_out_data),
    .out_valid(m3_out_valid), .out_ready(m3_out_ready), .out_ch(m3_out_ch));

  int checks = 0;
  int errors = 0;

  // Reference state per instance (0=u0, 1=u1, 2=u3)
  int ev[3];
  int ed[3];
  int ec[3];
  int ep[3];

  function automatic int nch(int u);
    return (u == 2) ? 3 : 4;
  endfunction

  function automatic bit oready(int u);
    case (u)
      0:       return m0_out_ready;
      1:       return m1_out_ready;
      default: return m3_out_ready;
    endcase
  endfunction

  function automatic int grant_of(int u);
    int v;
    int s;
    case (u)
      0:       begin v = int'(m0_in_valid); s = int'(m0_sel); end
      1:       begin v = int'(m1_in_valid); s = -1; end
      default: begin v = int'(m3_in_valid); s = int'(m3_sel); end
    endcase
    if (u == 1) begin
      for (int i = 0; i < 4; i++) begin
        int idx;
        idx = (ep[1] + i) % 4;
        if (v[idx]) return idx;
      end
      return -1;
    end
    if (s < nch(u) && v[s]) return s;
    return -1;
  endfunction

  function automatic int word_of(int u, int g);
    case (u)
      0:       return int'((m0_in_data >> (8*g)) & 32'hFF);
      1:       return int'((m1_in_data >> (8*g)) & 32'hFF);
      default: return int'((m3_in_data >> (4*g)) & 12'hF);
    endcase
  endfunction

  function automatic int exp_ready(int u);
    int g;
    g = grant_of(u);
    if (rst_n !== 1'b1) return 0;
    if (g < 0 || !(ev[u] == 0 || oready(u))) return 0;
    return 1 << g;
  endfunction

  function automatic logic [31:0] act_ready(int u);
    case (u)
      0:       return 32'(m0_in_ready);
      1:       return 32'(m1_in_ready);
      default: return 32'(m3_in_ready);
    endcase
  endfunction

  function automatic logic [31:0] act_valid(int u);
    case (u)
      0:       return 32'(m0_out_valid);
      1:       return 32'(m1_out_valid);
      default: return 32'(m3_out_valid);
    endcase
  endfunction

  function automatic logic [31:0] act_data(int u);
    case (u)
      0:       return 32'(m0_out_data);
      1:       return 32'(m1_out_data);
      default: return 32'(m3_out_data);
    endcase
  endfunction

  function automatic logic [31:0] act_ch(int u);
    case (u)
      0:       return 32'(m0_out_ch);
      1:       return 32'(m1_out_ch);
      default: return 32'(m3_out_ch);
    endcase
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 3; u++) begin
      ev[u] = 0; ed[u] = 0; ec[u] = 0; ep[u] = 0;
    end
  endtask

  // One clock: predict from pre-edge inputs, advance, leave time at edge+1.
  task automatic tick();
    int g[3];
    int w[3];
    bit ld[3];
    for (int u = 0; u < 3; u++) begin
      g[u]  = grant_of(u);
      ld[u] = (ev[u] == 0) || oready(u);
      w[u]  = (g[u] >= 0) ? word_of(u, g[u]) : 0;
    end
    @(posedge clk);
    if (rst_n !== 1'b1) begin
      model_reset();
    end else begin
      for (int u = 0; u < 3; u++) begin
        if (ld[u]) begin
          if (g[u] >= 0) begin
            ev[u] = 1; ed[u] = w[u]; ec[u] = g[u]; ep[u] = (g[u] + 1) % nch(u);
          end else begin
            ev[u] = 0;
          end
        end
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    m0_in_valid = 4'hF; m1_in_valid = 4'hF; m3_in_valid = 3'h7;
    m0_out_ready = 1'b1; m1_out_ready = 1'b1; m3_out_ready = 1'b1;
    m1_in_data = 32'h44332211;
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (m1_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", m1_out_valid); end
    checks++; if (m1_in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready_rr got %b want 0000", m1_in_ready); end
    checks++; if (m0_in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready_ext got %b want 0000", m0_in_ready); end
    checks++; if (m1_out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", m1_out_data); end
    checks++; if (m1_out_ch !== 2'd0) begin errors++; $display("FAIL reset_out_ch got %0d want 0", m1_out_ch); end
    rst_n = 1'b1;
    #1;
    checks++; if (m1_in_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got %b want 0001", m1_in_ready); end
    tick();
    checks++; if (m1_out_ch !== 2'd0 || m1_out_valid !== 1'b1) begin errors++; $display("FAIL reset_first_load ch %0d valid %b want ch 0 valid 1", m1_out_ch, m1_out_valid); end
  endtask

  task automatic test_mode0_sweep();
    logic [7:0] want;
    m0_in_data = 32'h00010001;
    m0_in_valid = 4'hF;
    m0_out_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      m0_sel = 2'(s);
      want = (s % 2 == 0) ? 8'h01 : 8'h00;
      tick();
      checks++;
      if (m0_out_data !== want || m0_out_ch !== 2'(s) || m0_out_valid !== 1'b1) begin
        errors++;
        $display("FAIL mode0_sweep sel %0d got data %h ch %0d valid %b want data %h ch %0d valid 1",
                 s, m0_out_data, m0_out_ch, m0_out_valid, want, s);
      end
    end
  endtask

  task automatic test_mode0_idle();
    m0_sel = 2'd2;
    m0_in_valid = 4'b1011;
    #1;
    checks++; if (m0_in_ready !== 4'b0000) begin errors++; $display("FAIL mode0_idle_ready got %b want 0000", m0_in_ready); end
    tick();
    checks++;
    if (m0_out_valid !== 1'b0 || m0_out_ch !== 2'd3 || m0_out_data !== 8'h00) begin
      errors++;
      $display("FAIL mode0_idle_drain got valid %b ch %0d data %h want valid 0 ch 3 data 00", m0_out_valid, m0_out_ch, m0_out_data);
    end
  endtask

  task automatic test_sel_out_of_range();
    m3_in_data = 12'hA5C;
    m3_in_valid = 3'b111;
    m3_sel = 2'd3;
    m3_out_ready = 1'b1;
    tick();
    tick();
    checks++; if (m3_in_ready !== 3'b000 || m3_out_valid !== 1'b0) begin errors++; $display("FAIL sel_oob got ready %b valid %b want 000 0", m3_in_ready, m3_out_valid); end
    m3_sel = 2'd2;
    #1;
    checks++; if (m3_in_ready !== 3'b100) begin errors++; $display("FAIL sel_last_ready got %b want 100", m3_in_ready); end
    tick();
    checks++; if (m3_out_data !== 4'hA || m3_out_ch !== 2'd2) begin errors++; $display("FAIL sel_last_load got data %h ch %0d want a 2", m3_out_data, m3_out_ch); end
  endtask

  task automatic test_mode1_fair();
    logic [7:0] want;
    m1_in_data = 32'h44332211;
    m1_in_valid = 4'hF;
    m1_out_ready = 1'b1;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      want = 8'(17 * (i % 4 + 1));
      tick();
      checks++;
      if (m1_out_ch !== 2'(i % 4) || m1_out_data !== want || m1_out_valid !== 1'b1) begin
        errors++;
        $display("FAIL mode1_fair step %0d got ch %0d data %h want ch %0d data %h", i, m1_out_ch, m1_out_data, i % 4, want);
      end
    end
  endtask

  task automatic test_backpressure();
    tick();
    checks++; if (m1_out_ch !== 2'd0 || m1_out_data !== 8'h11) begin errors++; $display("FAIL bp_load got ch %0d data %h want 0 11", m1_out_ch, m1_out_data); end
    m1_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (m1_in_ready !== 4'b0000) begin errors++; $display("FAIL bp_in_ready cyc %0d got %b want 0000", i, m1_in_ready); end
      tick();
      checks++;
      if (m1_out_valid !== 1'b1 || m1_out_ch !== 2'd0 || m1_out_data !== 8'h11) begin
        errors++;
        $display("FAIL bp_hold cyc %0d got valid %b ch %0d data %h want 1 0 11", i, m1_out_valid, m1_out_ch, m1_out_data);
      end
    end
    m1_out_ready = 1'b1;
    #1;
    checks++; if (m1_in_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_ready got %b want 0010", m1_in_ready); end
    tick();
    checks++; if (m1_out_ch !== 2'd1 || m1_out_data !== 8'h22 || m1_out_valid !== 1'b1) begin errors++; $display("FAIL bp_release_load got ch %0d data %h want 1 22", m1_out_ch, m1_out_data); end
  endtask

  task automatic test_sparse_reset();
    int seq [3];
    seq = '{1, 3, 1};
    m1_in_data = 32'h44332211;
    m1_in_valid = 4'b1010;
    m1_out_ready = 1'b1;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (m1_out_ch !== 2'(seq[i]) || m1_out_data !== 8'(17 * (seq[i] + 1))) begin
        errors++;
        $display("FAIL sparse_grant step %0d got ch %0d data %h want ch %0d", i, m1_out_ch, m1_out_data, seq[i]);
      end
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (m1_out_valid !== 1'b0 || m1_in_ready !== 4'b0000) begin errors++; $display("FAIL midrun_reset got valid %b ready %b want 0 0000", m1_out_valid, m1_in_ready); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checks++; if (m1_in_ready !== 4'b0010) begin errors++; $display("FAIL post_reset_ready got %b want 0010", m1_in_ready); end
    tick();
    checks++; if (m1_out_ch !== 2'd1 || m1_out_valid !== 1'b1) begin errors++; $display("FAIL post_reset_load got ch %0d valid %b want 1 1", m1_out_ch, m1_out_valid); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      m0_in_data = $urandom; m1_in_data = $urandom; m3_in_data = 12'($urandom);
      m0_in_valid = 4'($urandom); m1_in_valid = 4'($urandom); m3_in_valid = 3'($urandom);
      m0_sel = 2'($urandom); m1_sel = 2'($urandom); m3_sel = 2'($urandom);
      m0_out_ready = ($urandom_range(0, 3) != 0);
      m1_out_ready = ($urandom_range(0, 3) != 0);
      m3_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      for (int u = 0; u < 3; u++) begin
        checks++;
        if (act_ready(u) !== 32'(exp_ready(u))) begin
          errors++;
          $display("FAIL rand_in_ready inst %0d cyc %0d got %h want %h", u, c, act_ready(u), exp_ready(u));
        end
      end
      tick();
      for (int u = 0; u < 3; u++) begin
        checks++;
        if (act_valid(u) !== 32'(ev[u]) || act_data(u) !== 32'(ed[u]) || act_ch(u) !== 32'(ec[u])) begin
          errors++;
          $display("FAIL rand_out inst %0d cyc %0d got v %0h d %0h ch %0h want v %0d d %0h ch %0d",
                   u, c, act_valid(u), act_data(u), act_ch(u), ev[u], ed[u], ec[u]);
        end
      end
    end
  endtask

  initial begin
    m0_in_data = '0; m0_in_valid = '0; m0_sel = '0; m0_out_ready = 1'b0;
    m1_in_data = '0; m1_in_valid = '0; m1_sel = '0; m1_out_ready = 1'b0;
    m3_in_data = '0; m3_in_valid = '0; m3_sel = '0; m3_out_ready = 1'b0;
    model_reset();
    test_reset();
    test_mode0_sweep();
    test_mode0_idle();
    test_sel_out_of_range();
    test_mode1_fair();
    test_backpressure();
    test_sparse_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
